// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, ALU operation codes and decode bundle
// for the ALU-control pipeline stage.
package alu_ctrl_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_M    = 7'h01;

    typedef enum logic [4:0] {
        ADD    = 5'h00,
        SLL    = 5'h01,
        SLT    = 5'h02,
        SLTU   = 5'h03,
        XOR    = 5'h04,
        SRL    = 5'h05,
        OR     = 5'h06,
        AND    = 5'h07,
        SUB    = 5'h08,
        SRA    = 5'h0D,
        PASSB  = 5'h0F,
        MUL    = 5'h10,
        MULH   = 5'h11,
        MULHSU = 5'h12,
        MULHU  = 5'h13,
        DIV    = 5'h14,
        DIVU   = 5'h15,
        REM    = 5'h16,
        REMU   = 5'h17
    } alu_op_e;

    typedef struct packed {
        logic [4:0] ctrl;
        logic       illegal;
        logic       is_div;
    } alu_dec_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// Decode-side and execute-side handshake bundle
// of the ALU-control pipeline stage.
interface alu_ctrl_if #(
    parameter int CTRL_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              illegal;
    logic              is_div;

    modport master (
        output in_valid, opcode, funct3, funct7,
        output out_ready,
        input  in_ready, out_valid,
        input  alu_ctrl, illegal, is_div
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7,
        input  out_ready,
        output in_ready, out_valid,
        output alu_ctrl, illegal, is_div
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational {opcode, funct3, funct7} to ALU
// operation decoder with optional M-extension.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int EN_M = 0
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_dec_t   dec
);
    logic [4:0] ctrl;
    logic       ill;

    always_comb begin
        ctrl = '0;
        ill  = 1'b0;
        unique case (1'b1)
            opcode == OP: begin
                unique case (1'b1)
                    funct7 == F7_BASE:
                        ctrl = {2'b00, funct3};
                    funct7 == F7_ALT &&
                    (funct3 == 3'b000 || funct3 == 3'b101):
                        ctrl = {2'b01, funct3};
                    funct7 == F7_M && EN_M != 0:
                        ctrl = {2'b10, funct3};
                    default:
                        ill = 1'b1;
                endcase
            end
            opcode == OP_IMM: begin
                // Shift immediates reuse funct7 as the shift-type field
                if (funct3 == 3'b101 && funct7 == F7_ALT)
                    ctrl = SRA;
                else if (funct3[1:0] == 2'b01 &&
                         funct7 != F7_BASE)
                    ill = 1'b1;
                else
                    ctrl = {2'b00, funct3};
            end
            opcode == BRANCH: begin
                unique case (funct3[2:1])
                    2'b00:   ctrl = SUB;
                    2'b10:   ctrl = SLT;
                    2'b11:   ctrl = SLTU;
                    default: ill  = 1'b1;
                endcase
            end
            opcode == LOAD || opcode == STORE ||
            opcode == JAL || opcode == JALR ||
            opcode == AUIPC:
                ctrl = ADD;
            opcode == LUI:
                ctrl = PASSB;
            default:
                ill = 1'b1;
        endcase
    end

    assign dec = '{
        ctrl:    ctrl,
        illegal: ill,
        is_div:  ctrl[4] & ctrl[2]
    };
endmodule

// File: rtl/alu_ctrl_pipe.sv
// ALU-control stage: decode behind a 2-entry skid
// buffer with flush and divider issue throttling.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 5,
    parameter int EN_M    = 0,
    parameter int DIV_LAT = 4
) (
    input logic       clk,
    input logic       rst,
    input logic       flush,
    alu_ctrl_if.slave bus
);
    localparam int CNT_W =
        (DIV_LAT > 0) ? $clog2(DIV_LAT + 1) : 1;

    alu_dec_t         dec;
    alu_dec_t         main_q, main_d;
    alu_dec_t         skid_q, skid_d;
    logic             main_v, main_v_d;
    logic             skid_v, skid_v_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             thr;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;

    alu_ctrl_decode #(
        .EN_M(EN_M)
    ) u_dec (
        .opcode(bus.opcode),
        .funct3(bus.funct3),
        .funct7(bus.funct7),
        .dec   (dec)
    );

    assign thr       = (cnt != '0);
    assign out_valid = main_v & ~thr;
    assign in_fire   = bus.in_valid & in_ready_q;
    assign out_fire  = out_valid & bus.out_ready;

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v;
        skid_v_d = skid_v;
        cnt_d    = cnt;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            cnt_d    = '0;
        end else begin
            if (out_fire && main_q.is_div && DIV_LAT > 0)
                cnt_d = CNT_W'(DIV_LAT);
            else if (thr)
                cnt_d = cnt - 1'b1;
            // in_fire implies skid empty, so it never collides
            // with a skid-to-main move
            if (!main_v || out_fire) begin
                if (skid_v) begin
                    main_d   = skid_q;
                    main_v_d = 1'b1;
                    skid_v_d = 1'b0;
                end else if (in_fire) begin
                    main_d   = dec;
                    main_v_d = 1'b1;
                end else begin
                    main_v_d = 1'b0;
                end
            end else if (in_fire) begin
                skid_d   = dec;
                skid_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v     <= 1'b0;
            skid_v     <= 1'b0;
            cnt        <= '0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v     <= main_v_d;
            skid_v     <= skid_v_d;
            cnt        <= cnt_d;
            in_ready_q <= ~skid_v_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.alu_ctrl  = CTRL_W'(main_q.ctrl);
    assign bus.illegal   = main_q.illegal;
    assign bus.is_div    = main_q.is_div;
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: directed steps plus random
// traffic against a queue-based reference model.
module tb_alu_ctrl_pipe;
    import alu_ctrl_pkg::*;

    localparam int LAT = 4;

    typedef struct {
        logic [4:0] ctrl;
        logic       ill;
        logic       dv;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic flush0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   thr = 0;

    localparam logic [6:0] OPS [10] = '{
        OP, OP_IMM, BRANCH, LOAD, STORE,
        JAL, JALR, LUI, AUIPC, 7'b1110011
    };

    always #5 clk = ~clk;

    alu_ctrl_if #(.CTRL_W(5)) bus ();
    alu_ctrl_if #(.CTRL_W(5)) bus0 ();

    alu_ctrl_pipe #(
        .CTRL_W(5), .EN_M(1), .DIV_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );

    alu_ctrl_pipe #(
        .CTRL_W(5), .EN_M(0), .DIV_LAT(0)
    ) dut0 (
        .clk(clk), .rst(rst), .flush(flush0), .bus(bus0)
    );

    function automatic exp_t ref_dec(
        input bit en_m, input logic [6:0] op,
        input logic [2:0] f3, input logic [6:0] f7
    );
        exp_t e;
        e.ctrl = 5'd0;
        e.ill  = 1'b0;
        case (op)
            OP:
                if (f7 == 7'h00) e.ctrl = 5'(f3);
                else if (f7 == 7'h20 && (f3 == 0 || f3 == 5))
                    e.ctrl = 5'(8 + f3);
                else if (f7 == 7'h01 && en_m)
                    e.ctrl = 5'(16 + f3);
                else e.ill = 1'b1;
            OP_IMM:
                if (f3 == 5 && f7 == 7'h20) e.ctrl = 5'd13;
                else if ((f3 == 1 || f3 == 5) && f7 != 0)
                    e.ill = 1'b1;
                else e.ctrl = 5'(f3);
            BRANCH:
                case (f3)
                    0, 1:    e.ctrl = 5'd8;
                    4, 5:    e.ctrl = 5'd2;
                    6, 7:    e.ctrl = 5'd3;
                    default: e.ill = 1'b1;
                endcase
            LOAD, STORE, JAL, JALR, AUIPC: e.ctrl = 5'd0;
            LUI:     e.ctrl = 5'd15;
            default: e.ill = 1'b1;
        endcase
        e.dv = (e.ctrl >= 20 && e.ctrl <= 23);
        return e;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic compare();
        bit v;
        v = q.size() > 0 && thr == 0;
        chk("out_valid", bus.out_valid, v);
        chk("in_ready", bus.in_ready, q.size() < 2);
        if (v) begin
            chk("alu_ctrl", bus.alu_ctrl, q[0].ctrl);
            chk("illegal", bus.illegal, q[0].ill);
            chk("is_div", bus.is_div, q[0].dv);
        end
    endtask

    task automatic step(
        input bit iv, input logic [6:0] op,
        input logic [2:0] f3, input logic [6:0] f7,
        input bit ordy, input bit fl
    );
        bit   inf;
        bit   outf;
        exp_t e;
        exp_t h;
        bus.in_valid  = iv;
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.funct7    = f7;
        bus.out_ready = ordy;
        flush         = fl;
        inf  = iv && q.size() < 2;
        outf = ordy && q.size() > 0 && thr == 0;
        e    = ref_dec(1'b1, op, f3, f7);
        @(posedge clk);
        if (fl) begin
            q.delete();
            thr = 0;
        end else begin
            if (outf) begin
                h   = q.pop_front();
                thr = h.dv ? LAT : 0;
            end else if (thr > 0) begin
                thr--;
            end
            if (inf) q.push_back(e);
        end
        @(negedge clk);
        compare();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_alu_ctrl"}, bus.alu_ctrl, 0);
        chk({tag, "_illegal"}, bus.illegal, 0);
        chk({tag, "_is_div"}, bus.is_div, 0);
    endtask

    initial begin
        rst            = 1'b1;
        flush          = 1'b0;
        flush0         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.opcode     = '0;
        bus.funct3     = '0;
        bus.funct7     = '0;
        bus.out_ready  = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.opcode    = '0;
        bus0.funct3    = '0;
        bus0.funct7    = '0;
        bus0.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;

        // basic decode, 1-cycle latency
        step(1, OP, 3'd0, 7'h20, 1, 0);
        chk("sub_ctrl", bus.alu_ctrl, 5'h08);
        chk("sub_illegal", bus.illegal, 0);
        step(1, BRANCH, 3'd6, 7'h00, 1, 0);
        chk("bltu_ctrl", bus.alu_ctrl, 5'h03);
        step(1, OP_IMM, 3'd5, 7'h20, 1, 0);
        chk("srai_ctrl", bus.alu_ctrl, 5'h0D);
        step(1, OP, 3'd0, 7'h01, 1, 0);
        chk("mul_ctrl", bus.alu_ctrl, 5'h10);
        step(0, OP, 3'd0, 7'h00, 1, 0);

        // M-extension disabled instance
        bus0.in_valid = 1'b1;
        bus0.opcode   = OP;
        bus0.funct3   = 3'd0;
        bus0.funct7   = 7'h01;
        @(posedge clk);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        chk("nom_valid", bus0.out_valid, 1);
        chk("nom_illegal", bus0.illegal, 1);
        chk("nom_ctrl", bus0.alu_ctrl, 0);

        // back-pressure
        step(1, OP, 3'd4, 7'h00, 0, 0);
        step(1, OP, 3'd6, 7'h00, 0, 0);
        chk("bp_in_ready", bus.in_ready, 0);
        step(1, OP, 3'd7, 7'h00, 0, 0);
        chk("bp_hold_ctrl", bus.alu_ctrl, 5'h04);
        step(0, OP, 3'd0, 7'h00, 1, 0);
        chk("bp_second", bus.alu_ctrl, 5'h06);
        step(0, OP, 3'd0, 7'h00, 1, 0);
        chk("bp_no_third", bus.out_valid, 0);

        // divide throttle
        step(1, OP, 3'd4, 7'h01, 1, 0);
        chk("div_ctrl", bus.alu_ctrl, 5'h14);
        chk("div_flag", bus.is_div, 1);
        step(1, OP, 3'd0, 7'h00, 1, 0);
        chk("thr_low0", bus.out_valid, 0);
        for (int i = 1; i < LAT; i++) begin
            step(0, OP, 3'd0, 7'h00, 1, 0);
            chk($sformatf("thr_low%0d", i), bus.out_valid, 0);
        end
        step(0, OP, 3'd0, 7'h00, 1, 0);
        chk("thr_release", bus.out_valid, 1);
        chk("thr_add", bus.alu_ctrl, 5'h00);
        step(0, OP, 3'd0, 7'h00, 1, 0);

        // flush with both entries buffered
        step(1, OP, 3'd1, 7'h00, 0, 0);
        step(1, OP, 3'd2, 7'h00, 0, 0);
        step(1, OP, 3'd3, 7'h00, 0, 1);
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_ready", bus.in_ready, 1);
        step(0, OP, 3'd0, 7'h00, 1, 0);
        chk("flush_drop", bus.out_valid, 0);

        // reset in the middle of a throttle window
        step(1, OP, 3'd5, 7'h01, 0, 0);
        step(0, OP, 3'd0, 7'h00, 1, 0);
        step(1, OP, 3'd0, 7'h20, 1, 0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outs("rst_mid");
        q.delete();
        thr = 0;
        @(negedge clk);
        rst = 1'b0;
        compare();
        step(1, OP, 3'd0, 7'h00, 1, 0);
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_ctrl", bus.alu_ctrl, 5'h00);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            logic [6:0] f7;
            op = OPS[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, op,
                 3'($urandom), f7,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_pipe.md
# alu_ctrl_pipe

Pipelined, parametrised ALU-control decoder for the RV32I core, with optional M-extension decode. It sits between the decode and execute stages. It accepts {opcode, funct3, funct7} under a valid/ready handshake and registers the decoded ALU operation behind a 2-entry skid buffer. It also flags illegal encodings, supports a synchronous pipeline flush, and throttles issue after divide/remainder operations so the multicycle divider is not over-issued.

## Interface
Parameters:
- CTRL_W, 5: width of alu_ctrl (minimum 5).
- EN_M, 0: 1 enables decode of M-extension (funct7 = 7'b0000001 on OP).
- DIV_LAT, 4: cycles out_valid is held low after a DIV/DIVU/REM/REMU output handshake (0 disables throttling).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries and the throttle count.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  registered; high when the skid register is empty.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25].
- out_valid  out  1  decoded entry available.
- out_ready  in  1  execute stage accepts the entry.
- alu_ctrl  out  CTRL_W  decoded ALU operation, zero-extended.
- illegal  out  1  entry encodes an unsupported op; alu_ctrl is 0 for such an entry.
- is_div  out  1  entry is a M-extension divide or remainder.

## Operation
Decode is combinational. Ctrl is 5 bits, {m, alt, funct3}:
- OP (0110011):
  - funct7 = 0x00 -> {0,0,f3}.
  - funct7 = 0x20 with f3 ∈ {000,101} -> {0,1,f3}.
  - funct7 = 0x01 with EN_M -> {1,0,f3}.
  - Any other funct7/f3 combination -> illegal.
- OP-IMM (0010011):
  - {0,0,f3}.
  - f3 = 101 with funct7 = 0x20 -> {0,1,101} (SRAI).
  - f3 ∈ {001,101} with any other funct7 -> illegal.
- BRANCH (1100011):
  - f3 ∈ {000,001} -> 0_1000 (SUB).
  - f3 ∈ {100,101} -> 0_0010 (SLT).
  - f3 ∈ {110,111} -> 0_0011 (SLTU).
  - f3 ∈ {010,011} -> illegal.
- LOAD, STORE, JALR, AUIPC, JAL -> 0_0000 (ADD).
- LUI -> 0_1111 (pass operand B).
- Any other opcode -> illegal, ctrl 0.
- is_div = m & f3[2].

Buffering:
- The main register drives the outputs. The skid register holds one overflow entry.
- Input accept (in_valid & in_ready):
  - If main is empty, or main is draining this cycle, the entry goes to main.
  - Otherwise it goes to skid.
- When main drains and skid is full, skid moves to main in the same cycle.
- in_ready(next) = skid empty after the update.

Throttle:
- An output handshake with is_div = 1 loads cnt = DIV_LAT.
- While cnt ≠ 0: out_valid is forced to 0, cnt decrements each cycle, and buffered entries are held.
- Input acceptance continues, subject to skid occupancy.

Flush:
- Clears main-valid, skid-valid and cnt, and sets in_ready = 1.
- Takes priority over a simultaneous in or out handshake. The incoming entry is dropped.

## Timing
- Reset values: out_valid 0, in_ready 1, alu_ctrl 0, illegal 0, is_div 0, cnt 0, skid empty.
- Latency: an entry accepted at edge N appears on out_valid/alu_ctrl after edge N (1 cycle).
- Throughput: 1 entry/cycle with out_ready held high and no throttle.
- Back-pressure:
  - out_valid and all payload stay stable while out_valid & !out_ready.
  - in_ready drops the cycle after the skid register fills.
  - No entry is ever lost or duplicated.
- Simultaneous in and out handshake with skid empty: main is replaced and skid stays empty.
- Throttle, with DIV_LAT = 4: a div handshake at edge N holds out_valid low for the cycles after edges N..N+3. The next entry is visible after edge N+4.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Nothing is replayed.

## Structure
- Package alu_ctrl_pkg holds:
  - opcode localparams (OP, OP_IMM, BRANCH, LOAD, STORE, JAL, JALR, LUI, AUIPC).
  - alu_op_e enum of the 5-bit codes (ADD, SUB, SLT, SLTU, PASSB, MUL…REMU).
  - packed struct alu_dec_t {ctrl, illegal, is_div}.
- Sub-module alu_ctrl_decode: combinational, parameter EN_M, returns alu_dec_t. The top level contains only the skid buffer, the throttle counter and flush handling.

## Test plan
- Reset, then SUB (opcode 0110011, f3 000, f7 0x20) with out_ready = 1 -> alu_ctrl 0x08 one cycle later, illegal 0.
- BLTU (1100011, f3 110), then SRAI (0010011, f3 101, f7 0x20), then f7 0x01 R-type with EN_M = 0 -> 0x03, 0x0D, then illegal = 1 with ctrl 0.
- Back-pressure: out_ready = 0, push 3 entries -> first two accepted, in_ready low after the 2nd, order preserved on release.
- EN_M = 1, DIV_LAT = 4: DIV (f3 100) followed by ADD -> is_div 1, ctrl 0x14; out_valid low 4 cycles; then ADD (0x00).
- Flush while both entries are buffered and in_valid is high -> next cycle out_valid 0, in_ready 1, incoming entry dropped.
- Assert rst mid-throttle -> all outputs at reset values immediately; after release, an ADD passes with 1-cycle latency.
